// File: rtl/pingpong_pkg.sv
// Shared types and helpers for the ping-pong DDR read-back controller.
// Bank states track one bank's data from burst request through final output.
package pingpong_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_RUN  = 1'b1
  } ctrl_state_t;

  localparam int NUM_BANKS = 2;

  function automatic logic other_bank(input logic idx);
    return ~idx;
  endfunction

  // A bank presents data downstream from the moment it is full until it is emptied.
  function automatic logic bank_has_data(input bank_state_t s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction

endpackage

// File: rtl/pingpong_bank.sv
// One ping-pong bank: burst-sized storage with its own write/read pointers
// and lifecycle state (EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY).
module pingpong_bank
  import pingpong_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              claim,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output bank_state_t       state,
  output bank_state_t       state_next,
  output logic              fill_done,
  output logic              drain_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  bank_state_t       state_q, state_d;
  logic              wr_fire;
  logic              rd_fire;

  always_comb begin
    wr_fire    = wr_en && (state_q == BANK_FILLING);
    rd_fire    = rd_en && bank_has_data(state_q);
    fill_done  = wr_fire && (wr_ptr_q == PTR_W'(DEPTH - 1));
    drain_done = rd_fire && (rd_ptr_q == PTR_W'(DEPTH - 1));
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    // DEPTH is a power of two, so both pointers wrap back to 0 on the last word.
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case (state_q)
      BANK_EMPTY:    if (claim)      state_d = BANK_FILLING;
      BANK_FILLING:  if (fill_done)  state_d = BANK_FULL;
      BANK_FULL:     if (rd_fire)    state_d = BANK_DRAINING;
      BANK_DRAINING: if (drain_done) state_d = BANK_EMPTY;
      default:                       state_d = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BANK_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  // Asynchronous read: the head word must be on m_data the same cycle the bank turns FULL.
  assign rd_data    = mem_q[rd_ptr_q];
  assign state      = state_q;
  assign state_next = state_d;

endmodule

// File: rtl/pingpong_readback.sv
// Ping-pong DDR read-back: fetches fixed-size bursts into two alternating banks
// and streams them out in order on a valid/ready interface.
module pingpong_readback
  import pingpong_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BANK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_bursts,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [1:0]        bank_full,
  output logic              error
);

  localparam int BURST_BYTES = BANK_DEPTH * (DATA_W / 8);

  ctrl_state_t       ctrl_q, ctrl_d;
  logic [15:0]       num_q, num_d;
  logic [15:0]       issued_q, issued_d;
  logic [15:0]       drained_q, drained_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              outstanding_q, outstanding_d;
  logic              fill_ptr_q, fill_ptr_d;
  logic              drain_ptr_q, drain_ptr_d;
  logic              rd_req_q, rd_req_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              start_acc;
  logic              req_fire;
  logic              beat_ok;
  logic              out_fire;

  bank_state_t       bank_state      [NUM_BANKS];
  bank_state_t       bank_state_next [NUM_BANKS];
  logic [DATA_W-1:0] bank_rdata      [NUM_BANKS];
  logic [1:0]        bank_claim;
  logic [1:0]        bank_wr;
  logic [1:0]        bank_rd;
  logic [1:0]        bank_fill_done;
  logic [1:0]        bank_drain_done;

  always_comb begin
    start_acc = start && (ctrl_q == CTRL_IDLE);
    req_fire  = rd_req_q && rd_ack;
    beat_ok   = rd_data_valid && outstanding_q;
    m_valid   = bank_has_data(bank_state[drain_ptr_q]);
    m_data    = bank_rdata[drain_ptr_q];
    out_fire  = m_valid && m_ready;
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign bank_claim[gi] = req_fire && (fill_ptr_q == 1'(gi));
    assign bank_wr[gi]    = beat_ok && (fill_ptr_q == 1'(gi));
    assign bank_rd[gi]    = out_fire && (drain_ptr_q == 1'(gi));
    assign bank_full[gi]  = bank_has_data(bank_state[gi]);

    pingpong_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (BANK_DEPTH)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .claim      (bank_claim[gi]),
      .wr_en      (bank_wr[gi]),
      .wr_data    (rd_data),
      .rd_en      (bank_rd[gi]),
      .rd_data    (bank_rdata[gi]),
      .state      (bank_state[gi]),
      .state_next (bank_state_next[gi]),
      .fill_done  (bank_fill_done[gi]),
      .drain_done (bank_drain_done[gi])
    );
  end

  always_comb begin
    ctrl_d        = ctrl_q;
    num_d         = num_q;
    base_d        = base_q;
    issued_d      = issued_q;
    drained_d     = drained_q;
    outstanding_d = outstanding_q;
    fill_ptr_d    = fill_ptr_q;
    drain_ptr_d   = drain_ptr_q;
    done_d        = 1'b0;
    // Beats with no burst in flight are dropped and latched as a protocol error.
    error_d       = error_q | (rd_data_valid && !outstanding_q);

    if (start_acc) begin
      num_d       = num_bursts;
      base_d      = base_addr;
      issued_d    = '0;
      drained_d   = '0;
      fill_ptr_d  = 1'b0;
      drain_ptr_d = 1'b0;
      if (num_bursts == 16'd0) done_d = 1'b1;
      else                     ctrl_d = CTRL_RUN;
    end else if (ctrl_q == CTRL_RUN) begin
      if (req_fire) begin
        issued_d      = issued_q + 16'd1;
        outstanding_d = 1'b1;
      end
      if (bank_fill_done[fill_ptr_q]) begin
        outstanding_d = 1'b0;
        fill_ptr_d    = other_bank(fill_ptr_q);
      end
      if (bank_drain_done[drain_ptr_q]) begin
        drained_d   = drained_q + 16'd1;
        drain_ptr_d = other_bank(drain_ptr_q);
        if (drained_d == num_q) begin
          ctrl_d = CTRL_IDLE;
          done_d = 1'b1;
        end
      end
    end

    // Look at next-cycle bank state so a refill request can follow a drain by one cycle.
    rd_req_d  = (ctrl_d == CTRL_RUN) && (issued_d < num_d) && !outstanding_d &&
                (bank_state_next[fill_ptr_d] == BANK_EMPTY);
    rd_addr_d = base_d + (ADDR_W'(issued_d) * ADDR_W'(BURST_BYTES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= CTRL_IDLE;
      num_q         <= '0;
      base_q        <= '0;
      issued_q      <= '0;
      drained_q     <= '0;
      outstanding_q <= 1'b0;
      fill_ptr_q    <= 1'b0;
      drain_ptr_q   <= 1'b0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      num_q         <= num_d;
      base_q        <= base_d;
      issued_q      <= issued_d;
      drained_q     <= drained_d;
      outstanding_q <= outstanding_d;
      fill_ptr_q    <= fill_ptr_d;
      drain_ptr_q   <= drain_ptr_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign busy    = (ctrl_q == CTRL_RUN);
  assign done    = done_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign error   = error_q;

endmodule
